// File: rtl/tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state codes, opcodes, IR capture pattern.
package tap_pkg;

    localparam logic [3:0] ST_TLR     = 4'hF;
    localparam logic [3:0] ST_RTI     = 4'hC;
    localparam logic [3:0] ST_SEL_DR  = 4'h7;
    localparam logic [3:0] ST_CAP_DR  = 4'h6;
    localparam logic [3:0] ST_SH_DR   = 4'h2;
    localparam logic [3:0] ST_EX1_DR  = 4'h1;
    localparam logic [3:0] ST_PAU_DR  = 4'h3;
    localparam logic [3:0] ST_EX2_DR  = 4'h0;
    localparam logic [3:0] ST_UPD_DR  = 4'h5;
    localparam logic [3:0] ST_SEL_IR  = 4'h4;
    localparam logic [3:0] ST_CAP_IR  = 4'hE;
    localparam logic [3:0] ST_SH_IR   = 4'hA;
    localparam logic [3:0] ST_EX1_IR  = 4'h9;
    localparam logic [3:0] ST_PAU_IR  = 4'hB;
    localparam logic [3:0] ST_EX2_IR  = 4'h8;
    localparam logic [3:0] ST_UPD_IR  = 4'hD;

    localparam logic [3:0] OP_BYPASS   = 4'hF;
    localparam logic [3:0] OP_IDCODE   = 4'h1;
    localparam logic [3:0] OP_USERDATA = 4'h8;

    localparam logic [3:0] CAP_PAT = 4'b0101;

endpackage

// File: rtl/tap_shift_reg.sv
// Width-parameterised TAP shift register: sync clear, capture, right shift, hold.
module tap_shift_reg
    import tap_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         cap,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] cap_val,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (cap) begin
            q <= cap_val;
        end else if (shift) begin
            q <= {sin, q[W-1:1]};
        end
    end

endmodule

// File: rtl/tap_ir_dr_stage.sv
// TAP IR/DR register stage: IR, bypass, user DR, TDO mux.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register.
module tap_ir_dr_stage
    import tap_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          DR_W       = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B
) (
    input  logic            GCLK_Pad,
    input  logic            TRST_N_Pad,
    input  logic            state_obs0_Pad,
    input  logic            state_obs1_Pad,
    input  logic            state_obs2_Pad,
    input  logic            state_obs3_Pad,
    input  logic            TDI_Pad,
    output logic            TDO_Pad,
    output logic            TDO_EN_Pad,
    output logic [IR_W-1:0] ir_Pad,
    output logic [DR_W-1:0] user_dr_Pad,
    output logic            user_upd_Pad
);

    localparam logic [IR_W-1:0] IR_CAP = IR_W'(CAP_PAT);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = IR_W'(OP_IDCODE);
`else
    localparam logic [IR_W-1:0] IR_RST = IR_W'(OP_BYPASS);
`endif

    logic [3:0]      s;
    logic            tlr;
    logic            cap_ir;
    logic            sh_ir;
    logic            upd_ir;
    logic            cap_dr;
    logic            sh_dr;
    logic            upd_dr;
    logic            sel_user;
    logic            sel_id;
    logic            bypass;
    logic            dr_other;
    logic [IR_W-1:0] ir_shift;
    logic [DR_W-1:0] user_shift;

    assign s      = {state_obs3_Pad, state_obs2_Pad,
                     state_obs1_Pad, state_obs0_Pad};
    assign tlr    = (s == ST_TLR);
    assign cap_ir = (s == ST_CAP_IR);
    assign sh_ir  = (s == ST_SH_IR);
    assign upd_ir = (s == ST_UPD_IR);
    assign cap_dr = (s == ST_CAP_DR);
    assign sh_dr  = (s == ST_SH_DR);
    assign upd_dr = (s == ST_UPD_DR);

    assign sel_user = (ir_Pad == IR_W'(OP_USERDATA));

    tap_shift_reg #(.W(IR_W), .RST_VAL(IR_CAP)) u_ir (
        .clk     (GCLK_Pad),
        .rst_n   (TRST_N_Pad),
        .clr     (tlr),
        .cap     (cap_ir),
        .shift   (sh_ir),
        .sin     (TDI_Pad),
        .cap_val (IR_CAP),
        .q       (ir_shift)
    );

    tap_shift_reg #(.W(DR_W), .RST_VAL('0)) u_user (
        .clk     (GCLK_Pad),
        .rst_n   (TRST_N_Pad),
        .clr     (tlr),
        .cap     (cap_dr),
        .shift   (sh_dr & sel_user),
        .sin     (TDI_Pad),
        .cap_val (user_dr_Pad),
        .q       (user_shift)
    );

`ifdef TAP_IDCODE_EN
    logic [31:0] id_shift;

    assign sel_id = (ir_Pad == IR_W'(OP_IDCODE));

    tap_shift_reg #(.W(32), .RST_VAL(IDCODE_VAL)) u_id (
        .clk     (GCLK_Pad),
        .rst_n   (TRST_N_Pad),
        .clr     (tlr),
        .cap     (cap_dr),
        .shift   (sh_dr & sel_id),
        .sin     (TDI_Pad),
        .cap_val (IDCODE_VAL),
        .q       (id_shift)
    );

    assign dr_other = sel_id ? id_shift[0] : bypass;
`else
    logic id_unused;

    assign sel_id    = 1'b0;
    assign id_unused = ^{IDCODE_VAL, sel_id};
    assign dr_other  = bypass;
`endif

    always_ff @(posedge GCLK_Pad or negedge TRST_N_Pad) begin
        if (!TRST_N_Pad) begin
            ir_Pad       <= IR_RST;
            bypass       <= 1'b0;
            user_dr_Pad  <= '0;
            user_upd_Pad <= 1'b0;
        end else if (tlr) begin
            ir_Pad       <= IR_RST;
            bypass       <= 1'b0;
            user_dr_Pad  <= '0;
            user_upd_Pad <= 1'b0;
        end else begin
            user_upd_Pad <= upd_dr & sel_user;
            if (upd_ir) begin
                ir_Pad <= ir_shift;
            end
            if (cap_dr) begin
                bypass <= 1'b0;
            end else if (sh_dr) begin
                bypass <= TDI_Pad;
            end
            if (upd_dr && sel_user) begin
                user_dr_Pad <= user_shift;
            end
        end
    end

    // Unselected or illegal instructions fall through to bypass.
    always_comb begin
        TDO_Pad = 1'b0;
        if (sh_ir) begin
            TDO_Pad = ir_shift[0];
        end else if (sh_dr) begin
            TDO_Pad = sel_user ? user_shift[0] : dr_other;
        end
    end

    assign TDO_EN_Pad = sh_ir | sh_dr;

endmodule
